// File: rtl/case_1_mul_arbiter_if.sv
// ============================================================================
// Module   : case_1_mul_arbiter_if
// Brief    : Request and response channels of the shared-multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface case_1_mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int A_W   = 7,
  parameter int B_W   = 5,
  parameter int P_W   = 12
) ();

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [P_W-1:0]       rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

`default_nettype wire

// File: rtl/case_1_mul_arbiter.sv
// ============================================================================
// Module   : case_1_mul_arbiter
// Brief    : Round-robin arbiter sharing one full-precision signed multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module case_1_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int A_W   = 7,
  parameter int B_W   = 5,
  parameter int P_W   = 12
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  case_1_mul_arbiter_if.slave  bus
);

  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [A_W-1:0]         s1_a_q, s1_a_d;
  logic [B_W-1:0]         s1_b_q, s1_b_d;
  logic [ID_W-1:0]        s1_id_q, s1_id_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [P_W-1:0]         rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]        rsp_id_q, rsp_id_d;

  logic                   w_s2_adv;
  logic                   w_s1_adv;
  logic                   w_can_issue;
  logic                   w_found;
  logic [ID_W-1:0]        w_win;
  logic [N_REQ-1:0]       w_grant;
  logic                   w_xfer;
  logic [A_W-1:0]         w_sel_a;
  logic [B_W-1:0]         w_sel_b;
  logic signed [P_W-1:0]  w_a_ext;
  logic signed [P_W-1:0]  w_b_ext;
  logic signed [P_W-1:0]  w_prod;

  assign w_s2_adv    = !rsp_valid_q || bus.rsp_ready;
  assign w_s1_adv    = s1_valid_q && w_s2_adv;
  assign w_can_issue = !s1_valid_q || w_s2_adv;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if ((((int'(ptr_q) + k) % N_REQ) == j) && bus.req_valid[j]) begin
          w_found = 1'b1;
          w_win   = ID_W'(j);
        end
      end
    end
  end

  // Gating with ap_rst_n keeps every grant low while reset is held.
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_grant[i] = w_found && (w_win == ID_W'(i)) && bus.req_valid[i]
                   && w_can_issue && ap_rst_n;
    end
  end

  assign w_xfer = |w_grant;

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = bus.req_a[i*A_W +: A_W];
        w_sel_b = bus.req_b[i*B_W +: B_W];
      end
    end
  end

  assign w_a_ext = {{(P_W-A_W){s1_a_q[A_W-1]}}, s1_a_q};
  assign w_b_ext = {{(P_W-B_W){s1_b_q[B_W-1]}}, s1_b_q};
  assign w_prod  = w_a_ext * w_b_ext;

  always_comb begin
    ptr_d       = ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;

    if (w_xfer) begin
      s1_valid_d = 1'b1;
      s1_a_d     = w_sel_a;
      s1_b_d     = w_sel_b;
      s1_id_d    = w_win;
      ptr_d      = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    end else if (w_s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (w_s1_adv) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = w_prod;
      rsp_id_d    = s1_id_q;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = s1_valid_q || rsp_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_case_1_mul_arbiter.sv
// ============================================================================
// Module   : tb_case_1_mul_arbiter
// Brief    : Directed and random checks of the shared-multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_case_1_mul_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int A_W   = 7;
  localparam int B_W   = 5;
  localparam int P_W   = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  case_1_mul_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)) bus ();

  case_1_mul_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [A_W-1:0] a_arr [N_REQ];
  logic signed [B_W-1:0] b_arr [N_REQ];
  logic [N_REQ-1:0]      vld;
  logic                  rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply();
    bus.req_valid = vld;
    bus.rsp_ready = rdy;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a[i*A_W +: A_W] = a_arr[i];
      bus.req_b[i*B_W +: B_W] = b_arr[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pointer, two occupancy slots holding finished products,
  // and an order queue of every accepted request.
  int m_ptr = 0;
  bit m_s1_v = 0, m_s2_v = 0;
  int m_s1_prod = 0, m_s1_id = 0, m_s2_prod = 0, m_s2_id = 0;
  int sb_id[$];
  int sb_prod[$];

  always @(negedge clk) begin
    bit s2_adv, can, s1_adv;
    int win;
    logic [N_REQ-1:0] er;
    logic [P_W-1:0] ep;
    if (!rst_n) begin
      m_ptr = 0; m_s1_v = 0; m_s2_v = 0;
      m_s1_prod = 0; m_s1_id = 0; m_s2_prod = 0; m_s2_id = 0;
      sb_id.delete(); sb_prod.delete();
      check("rst_req_ready", 32'(bus.req_ready), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_rsp_data", 32'(bus.rsp_data), 0);
      check("rst_rsp_id", 32'(bus.rsp_id), 0);
    end else begin
      s2_adv = !m_s2_v || bus.rsp_ready;
      can    = !m_s1_v || s2_adv;
      s1_adv = m_s1_v && s2_adv;
      win    = -1;
      for (int k = 0; k < N_REQ; k++)
        if (win < 0 && bus.req_valid[(m_ptr + k) % N_REQ]) win = (m_ptr + k) % N_REQ;
      er = '0;
      if (can && win >= 0) er[win] = 1'b1;

      check("req_ready", 32'(bus.req_ready), 32'(er));
      check("req_ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_s2_v));
      check("busy", 32'(bus.busy), 32'(m_s1_v || m_s2_v));
      if (m_s2_v) begin
        ep = P_W'(m_s2_prod);
        check("rsp_data", 32'(bus.rsp_data), 32'(ep));
        check("rsp_id", 32'(bus.rsp_id), 32'(m_s2_id));
      end

      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_id.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_spurious: got response id %0d, expected none", bus.rsp_id);
        end else begin
          ep = P_W'(sb_prod.pop_front());
          check("sb_order_id", 32'(bus.rsp_id), 32'(sb_id.pop_front()));
          check("sb_order_data", 32'(bus.rsp_data), 32'(ep));
        end
      end

      if (s1_adv) begin
        m_s2_v = 1; m_s2_prod = m_s1_prod; m_s2_id = m_s1_id;
      end else if (bus.rsp_ready) begin
        m_s2_v = 0;
      end
      if (can && win >= 0) begin
        m_s1_v    = 1;
        m_s1_id   = win;
        m_s1_prod = int'($signed(bus.req_a[win*A_W +: A_W])) * int'($signed(bus.req_b[win*B_W +: B_W]));
        m_ptr     = (win + 1) % N_REQ;
        sb_id.push_back(m_s1_id);
        sb_prod.push_back(m_s1_prod);
      end else if (s1_adv) begin
        m_s1_v = 0;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    vld   = '0;
    rdy   = 1'b1;
    apply();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic single(input int id, input int a, input int b, input logic [P_W-1:0] exp_p);
    a_arr[id] = A_W'(a);
    b_arr[id] = B_W'(b);
    vld = '0; vld[id] = 1'b1; rdy = 1'b1;
    apply();
    @(negedge clk);
    check("single_ready", 32'(bus.req_ready), 32'(1) << id);
    tick();
    vld = '0; apply();
    check("single_lat_edge1", 32'(bus.rsp_valid), 0);
    tick();
    check("single_rsp_valid", 32'(bus.rsp_valid), 1);
    check("single_rsp_data", 32'(bus.rsp_data), 32'(exp_p));
    check("single_rsp_id", 32'(bus.rsp_id), 32'(id));
    tick();
  endtask

  initial begin
    int seq[$];
    int acc_cnt;
    int rid[$];
    int rdat[$];
    logic [N_REQ-1:0] acc;

    vld = '0; rdy = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
    apply();
    repeat (3) tick();
    check("reset_req_ready", 32'(bus.req_ready), 0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    tick();

    single(2, -64, -16, 12'h400);
    single(2, 63, 15, 12'h3B1);
    single(0, -64, 15, 12'hC40);
    single(3, 0, -16, 12'h000);

    // All four requesters held valid
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin a_arr[i] = A_W'(i + 1); b_arr[i] = B_W'(-(i + 1)); end
    vld = '1; apply();
    repeat (9) begin tick(); if (bus.rsp_valid) seq.push_back(int'(bus.rsp_id)); end
    check("fair4_count", 32'(seq.size()), 8);
    for (int i = 0; i < 8 && i < seq.size(); i++) check("fair4_seq", 32'(seq[i]), 32'(i % 4));
    vld = '0; apply();
    repeat (3) tick();

    // Only requesters 1 and 3
    do_reset();
    seq.delete();
    vld = 4'b1010; apply();
    repeat (7) begin tick(); if (bus.rsp_valid) seq.push_back(int'(bus.rsp_id)); end
    check("fair13_count", 32'(seq.size()), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++) check("fair13_seq", 32'(seq[i]), (i % 2 == 1) ? 32'd3 : 32'd1);
    vld = '0; apply();
    repeat (3) tick();

    // Backpressure
    do_reset();
    a_arr[0] = 7'sd5;   b_arr[0] = 5'sd3;
    a_arr[1] = -7'sd7;  b_arr[1] = -5'sd2;
    a_arr[2] = 7'sd63;  b_arr[2] = 5'sd15;
    a_arr[3] = -7'sd64; b_arr[3] = -5'sd16;
    vld = '1; rdy = 1'b0; apply();
    acc_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      acc_cnt += $countones(bus.req_ready & bus.req_valid);
      tick();
    end
    check("bp_accepts", 32'(acc_cnt), 2);
    @(negedge clk);
    check("bp_stall_ready", 32'(bus.req_ready), 0);
    check("bp_stall_busy", 32'(bus.busy), 1);
    tick();
    vld = '0; rdy = 1'b1; apply();
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        rid.push_back(int'(bus.rsp_id));
        rdat.push_back(int'(bus.rsp_data));
      end
      tick();
    end
    check("bp_rsp_count", 32'(rid.size()), 2);
    if (rid.size() == 2) begin
      check("bp_rsp0_id", 32'(rid[0]), 0);
      check("bp_rsp0_data", 32'(rdat[0]), 32'd15);
      check("bp_rsp1_id", 32'(rid[1]), 1);
      check("bp_rsp1_data", 32'(rdat[1]), 32'd14);
    end

    // Reset with both stages full
    vld = '1; rdy = 1'b0; apply();
    repeat (3) tick();
    check("mid_busy_before", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", 32'(bus.rsp_valid), 0);
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_req_ready", 32'(bus.req_ready), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_first_grant", 32'(bus.req_ready), 32'b0001);
    tick();
    vld = '0; rdy = 1'b1; apply();
    repeat (4) tick();

    // Random soak honouring the hold-until-accepted contract
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      acc = bus.req_ready & bus.req_valid;
      tick();
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i] || !vld[i]) begin
          vld[i]   = ($urandom_range(0, 3) != 0);
          a_arr[i] = A_W'($urandom);
          b_arr[i] = B_W'($urandom);
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      apply();
    end
    vld = '0; rdy = 1'b1; apply();
    repeat (4) tick();
    check("drain_idle", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/case_1_mul_arbiter.md
# case_1_mul_arbiter

Round-robin arbiter that shares one signed multiplier between `N_REQ` requesters. Each requester presents a signed operand pair on a valid/ready channel. The block grants one pair per cycle, registers the operands, multiplies them at full precision, and returns the product with the requester's index on one registered, back-pressurable response channel. It sits between the HLS-generated compute loops and the shared multiplier datapath, so several loops can use one DSP-class resource.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: width of the requester index; 2^ID_W >= N_REQ.
- `A_W`, 7: signed width of operand A.
- `B_W`, 5: signed width of operand B.
- `P_W`, 12: product width; fixed at A_W+B_W (full precision, no truncation).

Ports:
- `ap_clk`  in  1  single clock; all state updates on the rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester grant/accept; at most one bit high.
- `req_a`  in  N_REQ*A_W  packed operand A; requester i uses bits [i*A_W +: A_W], two's complement.
- `req_b`  in  N_REQ*B_W  packed operand B; requester i uses bits [i*B_W +: B_W], two's complement.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  P_W  signed product A*B.
- `rsp_id`  out  ID_W  index of the requester that issued the operands.
- `busy`  out  1  high while any pipeline stage holds an entry.

## Operation
- Two-entry pipeline:
  - S1 is the operand register: `s1_valid`, a, b, id.
  - S2 is the response register: `rsp_valid`, `rsp_data`, `rsp_id`.
- Stall rules:
  - `s2_adv = !rsp_valid | rsp_ready`.
  - `s1_adv = s1_valid & s2_adv`.
  - `can_issue = !s1_valid | s2_adv`.
- Arbitration:
  - Rotating pointer `ptr` (0..N_REQ-1).
  - The winner is the first index with `req_valid` set, searching ptr, ptr+1, … modulo N_REQ.
  - `req_ready[i]` = (i == winner) & `req_valid[i]` & `can_issue`. It is combinational from `req_valid` and the stall state.
- Handshake:
  - A transfer occurs when `req_valid[i] & req_ready[i]`.
  - On a transfer, S1 loads that requester's a, b and i, and `ptr` becomes winner+1 modulo N_REQ.
  - With no transfer, `ptr` holds.
- Requester contract: once `req_valid[i]` is high, it stays high with stable operands until accepted. Requesters must not make valid depend on ready.
- Product:
  - When `s1_adv`, S2 loads `rsp_data = $signed(a) * $signed(b)` (P_W bits, exact) and `rsp_id` = S1 id.
  - The multiply is combinational between S1 and S2.
- S1 `s1_valid` next state:
  - 1 if a transfer occurs this cycle.
  - Else 0 if `s1_adv`.
  - Else hold.
- S2 `rsp_valid` next state:
  - 1 if `s1_adv`.
  - Else 0 if `rsp_ready`.
  - Else hold.
- Response order equals grant order; no entry is dropped or duplicated.
- `busy = s1_valid | rsp_valid`.

## Timing
- Reset (`ap_rst_n` low, asynchronous) clears: `s1_valid`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `ptr`=0, S1 operand/id registers 0.
  - `req_ready` is all 0 while reset is asserted.
  - `busy`=0.
- Reset mid-operation discards all in-flight entries; no response is produced for them. Operation resumes on the first rising edge after deassertion.
- Latency: a transfer at rising edge k gives `rsp_valid`=1 with its data after edge k+1 (one cycle in S1, then registered into S2). Minimum two edges from accept to response visible.
- Throughput: one accept and one response per cycle while `rsp_ready`=1.
- Full pipeline (S1 and S2 valid, `rsp_ready`=0): `req_ready` is all 0. Entries hold indefinitely.
- Simultaneous events:
  - With S2 popped (`rsp_ready`=1), S1 advancing and a new accept in the same cycle, all three occur; occupancy stays 2.
  - With only S1 empty and S2 stalled, one accept is allowed, then the block stalls.
- Pointer wrap: after a grant to N_REQ-1, `ptr` becomes 0.

## Test plan
- Single request: requester 2 sends a=-64, b=-16 → `rsp_data`=12'h400 (1024), `rsp_id`=2, two edges after the accept.
- Extremes: a=63, b=15 → 945 (12'h3B1); a=-64, b=15 → -960 (12'hC40); a=0, b=-16 → 0.
- Fairness:
  - All 4 requesters hold valid continuously with `rsp_ready`=1 → grants and `rsp_id` sequence 0,1,2,3,0,1,…, one per cycle.
  - With only requesters 1 and 3 active → 1,3,1,3.
- Backpressure:
  - Hold `rsp_ready`=0 for 5 cycles with all requesters valid → exactly 2 accepts, then `req_ready`=0.
  - Release → responses in accept order, each exactly once, with correct products.
- Reset mid-flight: assert `ap_rst_n`=0 with both stages full → `rsp_valid`, `busy`, `req_ready` go 0 immediately. After release, the first grant goes to requester 0 (`ptr`=0).
- Random soak: 10k cycles, random valid/operands/`rsp_ready` → scoreboard matches the signed product and the round-robin order; `req_ready` is never multi-hot.
